scale_line_buf: RTL and testbench

Parametrised multi-line buffer for the horizontal/vertical scaler datapath. Incoming pixels are written line by line into a ring of NUM_BANKS single-line banks, with automatic bank rotation and occupancy tracking. For each requested output column, the block fetches two adjacent source pixels from each of the two oldest stored lines, plus the horizontal fractional weight, as the input to a bilinear interpolator. Write/read handshakes and a deferred line-release mechanism replace the external bank selection used by the previous generation.

---
 rtl/scale_line_buf_if.sv | 50 +++++
 rtl/scale_line_buf.sv | 184 ++++++++++++++++++
 tb/tb_scale_line_buf.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/scale_line_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : scale_line_buf_if
// Description : Bundles the configuration, write, read-request, release and
//               result signals of the scaler line buffer.
//               master : the client side (pixel source, column sequencer,
//                        interpolator)
//               slave  : the line buffer itself
// Ports       : line_width, flush, wr_valid/wr_ready/wr_data,
//               rd_valid/rd_ready/x_pos/x_scale, rd_release,
//               out_valid, x1..x4_data, frac, lines_avail
// Revision    : 1.0 - initial release
// ============================================================================
interface scale_line_buf_if #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int NUM_BANKS = 4,
    parameter int SCALE_W   = 10,
    parameter int FRAC_W    = 8,
    parameter int LVL_W     = $clog2(NUM_BANKS + 1)
);
    logic [ADDR_W:0]      line_width;
    logic                 flush;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_W-1:0]    wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_W-1:0]    x_pos;
    logic [SCALE_W-1:0]   x_scale;
    logic                 rd_release;
    logic                 out_valid;
    logic [DATA_W-1:0]    x1_data;
    logic [DATA_W-1:0]    x2_data;
    logic [DATA_W-1:0]    x3_data;
    logic [DATA_W-1:0]    x4_data;
    logic [FRAC_W-1:0]    frac;
    logic [LVL_W-1:0]     lines_avail;

    modport master (
        output line_width, flush, wr_valid, wr_data, rd_valid, x_pos, x_scale, rd_release,
        input  wr_ready, rd_ready, out_valid, x1_data, x2_data, x3_data, x4_data, frac, lines_avail
    );

    modport slave (
        input  line_width, flush, wr_valid, wr_data, rd_valid, x_pos, x_scale, rd_release,
        output wr_ready, rd_ready, out_valid, x1_data, x2_data, x3_data, x4_data, frac, lines_avail
    );
endinterface
`default_nettype wire

// File: rtl/scale_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : scale_line_buf
// Description : Ring of NUM_BANKS single-line banks for the bilinear scaler.
//               Pixels are written line by line with automatic bank rotation.
//               Each accepted read returns pixels idx/idx2 of the two oldest
//               lines plus the horizontal weight, three cycles later.
// Ports       : clk   - clock
//               rstn  - asynchronous active-low reset
//               bus   - scale_line_buf_if.slave (write, read, release, result)
// Revision    : 1.0 - initial release
// ============================================================================
module scale_line_buf #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int NUM_BANKS = 4,
    parameter int SCALE_W   = 10,
    parameter int FRAC_W    = 8,
    parameter int LVL_W     = $clog2(NUM_BANKS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    scale_line_buf_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int P_W    = SCALE_W + ADDR_W;
    localparam int I_W    = P_W - FRAC_W;
    localparam int CW     = (I_W > ADDR_W + 1) ? I_W : ADDR_W + 1;

    function automatic logic [BANK_W-1:0] f_next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    // Bank storage, not reset
    logic [DATA_W-1:0] r_mem [NUM_BANKS][DEPTH];

    // Pointers and occupancy
    logic [BANK_W-1:0] r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [BANK_W-1:0] r_rd_base;
    logic [LVL_W-1:0]  r_lines;
    logic              r_rel_pend;

    // Read pipe
    logic              r_v1, r_v2, r_v3;
    logic [P_W-1:0]    r_p1;
    logic [BANK_W-1:0] r_ba1, r_bb1, r_ba2, r_bb2;
    logic [ADDR_W-1:0] r_idx2_a, r_idx2_b;
    logic [FRAC_W-1:0] r_frac2;
    logic [DATA_W-1:0] r_x1, r_x2, r_x3, r_x4;
    logic [FRAC_W-1:0] r_frac3;

    logic              w_wr_ready, w_rd_ready;
    logic              w_wr_fire, w_rd_fire, w_line_done;
    logic              w_rel_want, w_do_rel;
    logic [ADDR_W:0]   w_lw_m1;
    logic [CW-1:0]     w_idx_raw;
    logic [ADDR_W-1:0] w_idx_c;
    logic [ADDR_W:0]   w_idx_inc;
    logic [ADDR_W-1:0] w_idx2_c;

    assign w_wr_ready  = r_lines < LVL_W'(NUM_BANKS);
    assign w_rd_ready  = (r_lines >= LVL_W'(2)) && !r_rel_pend;
    assign w_wr_fire   = bus.wr_valid && w_wr_ready && !bus.flush;
    assign w_rd_fire   = bus.rd_valid && w_rd_ready && !bus.flush;
    assign w_lw_m1     = bus.line_width - 1'b1;
    assign w_line_done = w_wr_fire && ({1'b0, r_wr_addr} == w_lw_m1);

    // A release (new or pending) retires the oldest bank once no accepted
    // read still has to fetch from it. Stage S2 performs its RAM fetch on the
    // closing edge, so only S1 holds the bank; the release therefore lands on
    // the same edge that moves the last read into the output register.
    assign w_rel_want = r_rel_pend || (bus.rd_release && (r_lines >= LVL_W'(2)));
    assign w_do_rel   = w_rel_want && !r_v1;

    // Column address: truncate, clamp to last pixel, neighbour clamped too
    assign w_idx_raw = CW'(r_p1[P_W-1:FRAC_W]);
    assign w_idx_c   = (w_idx_raw > CW'(w_lw_m1)) ? ADDR_W'(w_lw_m1) : ADDR_W'(w_idx_raw);
    assign w_idx_inc = {1'b0, w_idx_c} + 1'b1;
    assign w_idx2_c  = (w_idx_inc > w_lw_m1) ? ADDR_W'(w_lw_m1) : ADDR_W'(w_idx_inc);

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_bank  <= '0;
            r_wr_addr  <= '0;
            r_rd_base  <= '0;
            r_lines    <= '0;
            r_rel_pend <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_p1       <= '0;
            r_ba1      <= '0;
            r_bb1      <= '0;
            r_ba2      <= '0;
            r_bb2      <= '0;
            r_idx2_a   <= '0;
            r_idx2_b   <= '0;
            r_frac2    <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_x3       <= '0;
            r_x4       <= '0;
            r_frac3    <= '0;
        end else if (bus.flush) begin
            r_wr_bank  <= '0;
            r_wr_addr  <= '0;
            r_rd_base  <= '0;
            r_lines    <= '0;
            r_rel_pend <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
        end else begin
            // Write side
            if (w_wr_fire) begin
                if (w_line_done) begin
                    r_wr_addr <= '0;
                    r_wr_bank <= f_next_bank(r_wr_bank);
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end

            // Release side
            if (w_do_rel) begin
                r_rd_base <= f_next_bank(r_rd_base);
            end
            r_rel_pend <= w_rel_want && r_v1;

            case ({w_line_done, w_do_rel})
                2'b10:   r_lines <= r_lines + 1'b1;
                2'b01:   r_lines <= r_lines - 1'b1;
                default: r_lines <= r_lines;
            endcase

            // S1: product and bank pair of the two oldest lines
            r_v1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_p1  <= P_W'(bus.x_scale) * P_W'(bus.x_pos);
                r_ba1 <= r_rd_base;
                r_bb1 <= f_next_bank(r_rd_base);
            end

            // S2: clamped addresses and weight
            r_v2 <= r_v1;
            if (r_v1) begin
                r_idx2_a <= w_idx_c;
                r_idx2_b <= w_idx2_c;
                r_frac2  <= r_p1[FRAC_W-1:0];
                r_ba2    <= r_ba1;
                r_bb2    <= r_bb1;
            end

            // S3: RAM fetch straight into the output registers; held otherwise
            r_v3 <= r_v2;
            if (r_v2) begin
                r_x1    <= r_mem[r_ba2][r_idx2_a];
                r_x2    <= r_mem[r_ba2][r_idx2_b];
                r_x3    <= r_mem[r_bb2][r_idx2_a];
                r_x4    <= r_mem[r_bb2][r_idx2_b];
                r_frac3 <= r_frac2;
            end
        end
    end

    assign bus.wr_ready    = w_wr_ready;
    assign bus.rd_ready    = w_rd_ready;
    assign bus.out_valid   = r_v3;
    assign bus.x1_data     = r_x1;
    assign bus.x2_data     = r_x2;
    assign bus.x3_data     = r_x3;
    assign bus.x4_data     = r_x4;
    assign bus.frac        = r_frac3;
    assign bus.lines_avail = r_lines;
endmodule
`default_nettype wire

// File: tb/tb_scale_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_scale_line_buf
// Description : Directed self-checking bench for scale_line_buf with 8-pixel
//               lines: fill, address arithmetic, clamping, ring wrap,
//               immediate/deferred release, flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scale_line_buf;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    scale_line_buf_if bus_if ();

    scale_line_buf dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last pixel.
    task automatic write_line(input int base);
        for (int i = 0; i < 8; i++) begin
            bus_if.wr_valid = 1'b1;
            bus_if.wr_data  = 16'(base + i);
            @(negedge clk);
        end
        bus_if.wr_valid = 1'b0;
    endtask

    task automatic release_pulse();
        bus_if.rd_release = 1'b1;
        @(negedge clk);
        bus_if.rd_release = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [9:0] sc, input logic [10:0] pos,
                            input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] e3, input logic [15:0] e4,
                            input logic [7:0] ef);
        chk({tag, " rd_ready"}, bus_if.rd_ready, 1);
        bus_if.rd_valid = 1'b1;
        bus_if.x_scale  = sc;
        bus_if.x_pos    = pos;
        @(negedge clk);
        bus_if.rd_valid = 1'b0;
        chk({tag, " ov+1"}, bus_if.out_valid, 0);
        @(negedge clk);
        chk({tag, " ov+2"}, bus_if.out_valid, 0);
        @(negedge clk);
        chk({tag, " ov+3"}, bus_if.out_valid, 1);
        chk({tag, " x1"}, bus_if.x1_data, e1);
        chk({tag, " x2"}, bus_if.x2_data, e2);
        chk({tag, " x3"}, bus_if.x3_data, e3);
        chk({tag, " x4"}, bus_if.x4_data, e4);
        chk({tag, " frac"}, bus_if.frac, ef);
        @(negedge clk);
        chk({tag, " ov+4"}, bus_if.out_valid, 0);
        chk({tag, " hold"}, bus_if.x1_data, e1);
    endtask

    initial begin
        bus_if.line_width = 12'd8;
        bus_if.flush      = 1'b0;
        bus_if.wr_valid   = 1'b0;
        bus_if.wr_data    = '0;
        bus_if.rd_valid   = 1'b0;
        bus_if.x_pos      = '0;
        bus_if.x_scale    = '0;
        bus_if.rd_release = 1'b0;

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst lines", bus_if.lines_avail, 0);
        chk("rst wr_ready", bus_if.wr_ready, 1);
        chk("rst rd_ready", bus_if.rd_ready, 0);
        chk("rst out_valid", bus_if.out_valid, 0);
        chk("rst x1", bus_if.x1_data, 0);
        chk("rst frac", bus_if.frac, 0);

        // Fill two lines
        write_line(0);
        chk("fill1 lines", bus_if.lines_avail, 1);
        chk("fill1 rd_ready", bus_if.rd_ready, 0);
        write_line(100);
        chk("fill2 lines", bus_if.lines_avail, 2);
        chk("fill2 rd_ready", bus_if.rd_ready, 1);

        // Address arithmetic
        read_chk("unity3", 10'h100, 11'd3, 16'd3, 16'd4, 16'd103, 16'd104, 8'h00);
        read_chk("frac180", 10'h180, 11'd3, 16'd4, 16'd5, 16'd104, 16'd105, 8'h80);
        read_chk("frac0c0", 10'h0C0, 11'd5, 16'd3, 16'd4, 16'd103, 16'd104, 8'hC0);
        read_chk("edge7", 10'h100, 11'd7, 16'd7, 16'd7, 16'd107, 16'd107, 8'h00);
        read_chk("clamp20", 10'h100, 11'd20, 16'd7, 16'd7, 16'd107, 16'd107, 8'h00);

        // Back-to-back reads
        bus_if.rd_valid = 1'b1;
        bus_if.x_scale  = 10'h100;
        bus_if.x_pos    = 11'd1;
        @(negedge clk);
        bus_if.x_pos    = 11'd2;
        @(negedge clk);
        bus_if.rd_valid = 1'b0;
        @(negedge clk);
        chk("b2b a ov", bus_if.out_valid, 1);
        chk("b2b a x1", bus_if.x1_data, 1);
        chk("b2b a x4", bus_if.x4_data, 102);
        @(negedge clk);
        chk("b2b b ov", bus_if.out_valid, 1);
        chk("b2b b x1", bus_if.x1_data, 2);
        chk("b2b b x4", bus_if.x4_data, 103);
        @(negedge clk);
        chk("b2b end ov", bus_if.out_valid, 0);

        // Fill the ring
        write_line(200);
        write_line(300);
        chk("full lines", bus_if.lines_avail, 4);
        chk("full wr_ready", bus_if.wr_ready, 0);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 16'd999;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        chk("full no write", bus_if.lines_avail, 4);

        // Immediate release frees the oldest bank for the next line
        release_pulse();
        chk("rel lines", bus_if.lines_avail, 3);
        chk("rel wr_ready", bus_if.wr_ready, 1);
        write_line(400);
        chk("wrap lines", bus_if.lines_avail, 4);
        read_chk("base1", 10'h100, 11'd2, 16'd102, 16'd103, 16'd202, 16'd203, 8'h00);
        release_pulse();
        chk("rel2 lines", bus_if.lines_avail, 3);
        read_chk("base2", 10'h100, 11'd2, 16'd202, 16'd203, 16'd302, 16'd303, 8'h00);
        release_pulse();
        chk("rel3 lines", bus_if.lines_avail, 2);
        read_chk("base3", 10'h100, 11'd2, 16'd302, 16'd303, 16'd402, 16'd403, 8'h00);

        // Deferred release behind an in-flight read
        bus_if.rd_valid = 1'b1;
        bus_if.x_scale  = 10'h100;
        bus_if.x_pos    = 11'd0;
        @(negedge clk);
        bus_if.rd_valid   = 1'b0;
        bus_if.rd_release = 1'b1;
        @(negedge clk);
        bus_if.rd_release = 1'b0;
        chk("defer rd_ready", bus_if.rd_ready, 0);
        chk("defer lines", bus_if.lines_avail, 2);
        chk("defer ov", bus_if.out_valid, 0);
        @(negedge clk);
        chk("defer out ov", bus_if.out_valid, 1);
        chk("defer out lines", bus_if.lines_avail, 1);
        chk("defer x1", bus_if.x1_data, 300);
        chk("defer x2", bus_if.x2_data, 301);
        chk("defer x3", bus_if.x3_data, 400);
        chk("defer x4", bus_if.x4_data, 401);

        // Release with a single line is ignored
        @(negedge clk);
        release_pulse();
        chk("rel ignored", bus_if.lines_avail, 1);

        // Flush beats same-cycle release and kills the in-flight read
        write_line(500);
        chk("preflush lines", bus_if.lines_avail, 2);
        bus_if.rd_valid = 1'b1;
        bus_if.x_pos    = 11'd0;
        @(negedge clk);
        bus_if.rd_valid   = 1'b0;
        bus_if.rd_release = 1'b1;
        bus_if.flush      = 1'b1;
        @(negedge clk);
        bus_if.rd_release = 1'b0;
        bus_if.flush      = 1'b0;
        chk("flush lines", bus_if.lines_avail, 0);
        chk("flush rd_ready", bus_if.rd_ready, 0);
        chk("flush wr_ready", bus_if.wr_ready, 1);
        chk("flush ov a", bus_if.out_valid, 0);
        @(negedge clk);
        chk("flush ov b", bus_if.out_valid, 0);
        @(negedge clk);
        chk("flush ov c", bus_if.out_valid, 0);

        // Pointers restart at bank 0 after flush
        write_line(10);
        write_line(20);
        read_chk("postflush", 10'h100, 11'd1, 16'd11, 16'd12, 16'd21, 16'd22, 8'h00);

        // Asynchronous reset while a result is on the output
        bus_if.rd_valid = 1'b1;
        bus_if.x_pos    = 11'd1;
        @(negedge clk);
        bus_if.rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst pre ov", bus_if.out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst ov", bus_if.out_valid, 0);
        chk("arst lines", bus_if.lines_avail, 0);
        chk("arst x1", bus_if.x1_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
